// File: rtl/mul_share_pkg.sv
// Shared types for the two-requester multiplier arbiter.
// The count types are sized for the largest legal RBUF_DEPTH + LAT.
package mul_share_pkg;
    localparam int NREQ     = 2;
    localparam int MAX_RBUF = 4;
    localparam int MAX_LAT  = 8;
    localparam int CNT_W    = $clog2(MAX_RBUF + MAX_LAT + 1);

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/mul_share_rbuf.sv
// Per-requester result FIFO. Push and pop in the same cycle are allowed even when full.
module mul_share_rbuf
    import mul_share_pkg::*;
#(
    parameter int RESW  = 16,
    parameter int DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_push,
    input  logic [RESW-1:0] i_data,
    input  logic            i_pop,
    output logic [RESW-1:0] o_head,
    output cnt_t            o_occ
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [RESW-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    cnt_t            r_occ;
    logic            w_pop, w_push;

    assign w_pop  = i_pop && (r_occ != '0);
    assign w_push = i_push && ((r_occ != cnt_t'(DEPTH)) || w_pop);

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_occ <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else begin
            // Credit accounting upstream must make an overflowing push impossible.
            assert (!(i_push && !w_push));
            if (w_push) begin
                r_mem[r_wp] <= i_data;
                r_wp        <= inc(r_wp);
            end
            if (w_pop) r_rp <= inc(r_rp);
            r_occ <= r_occ + cnt_t'(w_push) - cnt_t'(w_pop);
        end
    end

    assign o_head = r_mem[r_rp];
    assign o_occ  = r_occ;
endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency, non-stallable multiplier between two requesters with credit-based result buffering.
// Define MUL_SHARE_STRICT_PRIO_EN for strict requester-0 priority instead of round-robin.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int OPW        = 8,
    parameter int RESW       = 16,
    parameter int LAT        = 3,
    parameter int RBUF_DEPTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OPW-1:0]  req_a,
    input  logic [NREQ*OPW-1:0]  req_b,
    output logic [OPW-1:0]       unit_a,
    output logic [OPW-1:0]       unit_b,
    input  logic [RESW-1:0]      unit_result,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [NREQ*RESW-1:0] rsp_data,
    output logic                 busy
);
    tag_t            r_tag  [LAT];
    cnt_t            r_infl [NREQ];
    cnt_t            w_occ  [NREQ];
    logic [NREQ-1:0] w_elig, w_gnt, w_push;
    logic            w_any;
    req_id_t         w_gid;
    tag_t            w_tag_out;

    assign w_tag_out = r_tag[LAT-1];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        // Credit is taken from registered state only, so a pop frees a slot one cycle later.
        assign w_elig[gi]    = !RST && req_valid[gi] &&
                               ((w_occ[gi] + r_infl[gi]) < cnt_t'(RBUF_DEPTH));
        assign w_push[gi]    = w_tag_out.valid && (w_tag_out.id == req_id_t'(gi));
        assign rsp_valid[gi] = (w_occ[gi] != '0);

        mul_share_rbuf #(.RESW(RESW), .DEPTH(RBUF_DEPTH)) u_rbuf (
            .CLK    (CLK),
            .RST    (RST),
            .i_push (w_push[gi]),
            .i_data (unit_result),
            .i_pop  (rsp_ready[gi]),
            .o_head (rsp_data[gi*RESW +: RESW]),
            .o_occ  (w_occ[gi])
        );
    end

`ifdef MUL_SHARE_STRICT_PRIO_EN
    always_comb begin
        w_gnt = '0;
        if (w_elig[0])      w_gnt[0] = 1'b1;
        else if (w_elig[1]) w_gnt[1] = 1'b1;
    end
`else
    req_id_t r_ptr;

    always_comb begin
        w_gnt = '0;
        if (w_elig[r_ptr])       w_gnt[r_ptr]  = 1'b1;
        else if (w_elig[~r_ptr]) w_gnt[~r_ptr] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST)        r_ptr <= 1'b0;
        else if (w_any) r_ptr <= ~w_gid;
    end
`endif

    assign w_any     = |w_gnt;
    assign w_gid     = w_gnt[1];
    assign req_ready = w_gnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            unit_a <= '0;
            unit_b <= '0;
            for (int k = 0; k < LAT; k++)  r_tag[k]  <= '0;
            for (int k = 0; k < NREQ; k++) r_infl[k] <= '0;
        end else begin
            unit_a   <= !w_any ? '0 : (w_gid ? req_a[OPW +: OPW] : req_a[0 +: OPW]);
            unit_b   <= !w_any ? '0 : (w_gid ? req_b[OPW +: OPW] : req_b[0 +: OPW]);
            r_tag[0] <= tag_t'({w_any, w_gid});
            for (int k = 1; k < LAT; k++)  r_tag[k]  <= r_tag[k-1];
            for (int k = 0; k < NREQ; k++) r_infl[k] <= r_infl[k] + cnt_t'(w_gnt[k]) - cnt_t'(w_push[k]);
        end
    end

    assign busy = (|rsp_valid) || (r_infl[0] != '0) || (r_infl[1] != '0);
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 3-cycle multiplier model and a per-requester result scoreboard.
module tb_mul_share_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req_valid = '0, rsp_ready = '0;
    logic [15:0] req_a = '0, req_b = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [7:0]  unit_a, unit_b;
    logic [15:0] unit_result;
    logic [31:0] rsp_data;
    logic        busy;

    int          n_vec = 0, n_err = 0;
    bit          mon_en = 1'b0;
    int          gq[$];
    logic [15:0] expq0[$], expq1[$];

    mul_share_arbiter #(.OPW(8), .RESW(16), .LAT(3), .RBUF_DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .unit_a(unit_a), .unit_b(unit_b),
        .unit_result(unit_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Multiplier: result valid three cycles after the issue cycle; never reset.
    logic [15:0] m1 = '0, m2 = '0;
    always @(posedge CLK) begin
        m1 <= unit_a * unit_b;
        m2 <= m1;
    end
    assign unit_result = m2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        @(negedge CLK);
        while (busy !== 1'b0 && k < 40) begin
            @(negedge CLK);
            k++;
        end
        chk("drain_busy", {31'b0, busy}, 0);
        chk("drain_queues", expq0.size() + expq1.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    logic [15:0] p;
                    p = req_a[i*8 +: 8] * req_b[i*8 +: 8];
                    gq.push_back(i);
                    if (i == 0) expq0.push_back(p);
                    else        expq1.push_back(p);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (i == 0 && expq0.size() > 0)      chk("rsp0_data", {16'b0, rsp_data[15:0]}, {16'b0, expq0.pop_front()});
                    else if (i == 1 && expq1.size() > 0) chk("rsp1_data", {16'b0, rsp_data[31:16]}, {16'b0, expq1.pop_front()});
                    else                                 chk("rsp_spurious", {31'b0, rsp_valid[i]}, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        int sp_exp [4];
        sp_exp = '{0, 0, 1, 1};

        // Reset: ready must stay low even with valid requests present.
        req_valid = 2'b11;
        @(negedge CLK);
        chk("rst_ready", {30'b0, req_ready}, 0);
        tick();
        req_valid = 2'b00;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_unit_a", {24'b0, unit_a}, 0);
        chk("rst_unit_b", {24'b0, unit_b}, 0);
        chk("rst_rsp_valid", {30'b0, rsp_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        mon_en = 1'b1;

        // Single op 12*10, result visible LAT+1 cycles after issue.
        tick();
        req_valid = 2'b01; req_a = 16'd12; req_b = 16'd10;
        @(negedge CLK);
        chk("single_ready", {30'b0, req_ready}, 1);
        tick();
        req_valid = 2'b00;
        @(negedge CLK);
        chk("single_unit_a", {24'b0, unit_a}, 12);
        chk("single_unit_b", {24'b0, unit_b}, 10);
        chk("single_busy", {31'b0, busy}, 1);
        tick();
        @(negedge CLK);
        chk("idle_unit_a", {24'b0, unit_a}, 0);
        tick();
        @(negedge CLK);
        chk("single_early", {30'b0, rsp_valid}, 0);
        tick();
        @(negedge CLK);
        chk("single_valid", {30'b0, rsp_valid}, 1);
        chk("single_data", {16'b0, rsp_data[15:0]}, 120);
        tick();
        rsp_ready = 2'b01;
        @(negedge CLK);
        chk("single_busy_held", {31'b0, busy}, 1);
        tick();
        rsp_ready = 2'b00;
        @(negedge CLK);
        chk("single_busy_drop", {31'b0, busy}, 0);
        chk("single_popped", {30'b0, rsp_valid}, 0);

        // Fairness: both valid, 255*255 on both channels.
        tick();
        gq.delete();
        rsp_ready = 2'b11; req_a = 16'hFFFF; req_b = 16'hFFFF; req_valid = 2'b11;
        for (int k = 0; k < 60 && gq.size() < 8; k++) tick();
        req_valid = 2'b00;
        drain();
        chk("fair_count", {31'b0, gq.size() >= 8}, 1);
        if (gq.size() >= 8) begin
`ifdef MUL_SHARE_STRICT_PRIO_EN
            for (int k = 0; k < 4; k++) chk("prio_order", gq[k], sp_exp[k]);
`else
            // Pointer favours requester 1 after the single op went to requester 0.
            for (int k = 0; k < 8; k++) chk("fair_order", gq[k], (k + 1) % 2);
`endif
        end

        // Backpressure on requester 1.
        tick();
        gq.delete();
        rsp_ready = 2'b01; req_a = {8'd7, 8'd3}; req_b = {8'd9, 8'd5}; req_valid = 2'b11;
        repeat (20) tick();
        @(negedge CLK);
        n0 = 0; n1 = 0;
        foreach (gq[k]) if (gq[k] == 1) n1++; else n0++;
        chk("bp_r1_grants", n1, 2);
        chk("bp_r0_active", {31'b0, n0 >= 4}, 1);
        chk("bp_r1_blocked", {31'b0, req_ready[1]}, 0);
        tick();
        rsp_ready = 2'b11;
        @(negedge CLK);
        chk("bp_pop_cycle", {31'b0, req_ready[1]}, 0);
        chk("bp_r1_valid", {31'b0, rsp_valid[1]}, 1);
        tick();
        req_valid = 2'b10;
        @(negedge CLK);
        chk("bp_r1_regrant", {30'b0, req_ready}, 2);
        tick();
        req_valid = 2'b00;
        drain();

        // Push and pop in the same cycle keep order: 4*6 then 5*7.
        tick();
        rsp_ready = 2'b00; req_a = 16'd4; req_b = 16'd6; req_valid = 2'b01;
        tick();
        req_a = 16'd5; req_b = 16'd7;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        rsp_ready = 2'b01;
        @(negedge CLK);
        chk("pp_head", {16'b0, rsp_data[15:0]}, 24);
        tick();
        @(negedge CLK);
        chk("pp_still_valid", {31'b0, rsp_valid[0]}, 1);
        chk("pp_second", {16'b0, rsp_data[15:0]}, 35);
        tick();
        @(negedge CLK);
        chk("pp_empty", {30'b0, rsp_valid}, 0);

        // Reset with three ops in flight; late products must be dropped.
        tick();
        rsp_ready = 2'b11; req_a = {8'd11, 8'd9}; req_b = {8'd13, 8'd9}; req_valid = 2'b01;
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00; RST = 1'b1; mon_en = 1'b0;
        tick();
        RST = 1'b0;
        expq0.delete(); expq1.delete();
        mon_en = 1'b1;
        @(negedge CLK);
        chk("mrst_unit_a", {24'b0, unit_a}, 0);
        for (int k = 0; k < 6; k++) begin
            chk("mrst_rsp_valid", {30'b0, rsp_valid}, 0);
            chk("mrst_rsp_data", rsp_data, 0);
            chk("mrst_busy", {31'b0, busy}, 0);
            tick();
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
